// File: rtl/cache_pkg.sv
// Shared types and line-layout helpers for the direct-mapped cache controller.
// A line is packed as {valid, tag, data} with data in the low bits.
package cache_pkg;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_SET_BITS = 2;
   localparam int DEF_CNT_W    = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      RESP
   } state_t;

   localparam int LINE_DATA_LSB = 0;

   function automatic int line_tag_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int line_valid_bit(input int data_w, input int tag_w);
      return data_w + tag_w;
   endfunction

   function automatic int line_width(input int data_w, input int tag_w);
      return data_w + tag_w + 1;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data array: one write port, one combinational read port.
// Only valid bits are reset; tag/data contents are don't-care while invalid.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int TAG_W    = DEF_ADDR_W - DEF_SET_BITS,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int SET_BITS = DEF_SET_BITS,
   parameter int LINE_W   = line_width(DATA_W, TAG_W)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                we,
   input  logic [SET_BITS-1:0] waddr,
   input  logic [LINE_W-1:0]   wline,
   input  logic [SET_BITS-1:0] raddr,
   output logic [LINE_W-1:0]   rline
);

   localparam int LINES     = 1 << SET_BITS;
   localparam int TAG_LSB   = line_tag_lsb(DATA_W);
   localparam int VALID_BIT = line_valid_bit(DATA_W, TAG_W);

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clear) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[waddr] <= wline[VALID_BIT];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[waddr]  <= wline[VALID_BIT-1:TAG_LSB];
         data_q[waddr] <= wline[TAG_LSB-1:LINE_DATA_LSB];
      end
   end

   assign rline = {valid_q[raddr], tag_q[raddr], data_q[raddr]};

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, write-allocate cache controller with a
// req/ack memory port and saturating hit/miss statistics.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int SET_BITS = DEF_SET_BITS,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W     = ADDR_W - SET_BITS;
   localparam int LINE_W    = line_width(DATA_W, TAG_W);
   localparam int TAG_LSB   = line_tag_lsb(DATA_W);
   localparam int VALID_BIT = line_valid_bit(DATA_W, TAG_W);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state, state_nxt;

   logic                req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic [SET_BITS-1:0] req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [LINE_W-1:0]   rd_line;
   logic [LINE_W-1:0]   wr_line;
   logic                line_we;
   logic                line_clear;
   logic                hit;
   logic                accept;

   assign req_idx   = req_addr[SET_BITS-1:0];
   assign req_tag   = req_addr[ADDR_W-1:SET_BITS];
   assign hit       = rd_line[VALID_BIT] & (rd_line[VALID_BIT-1:TAG_LSB] == req_tag);
   assign cpu_ready = (state == IDLE) & ~flush;
   assign accept    = cpu_ready & cpu_req;

   // Memory-side outputs derive from registered state, so reset drops them at once.
   assign mem_req   = (state == MEM_RD) | (state == MEM_WR);
   assign mem_we    = (state == MEM_WR);
   assign mem_addr  = req_addr;
   assign mem_wdata = req_wdata;
   assign cpu_valid = (state == RESP);

   cache_line_store #(
      .TAG_W    (TAG_W),
      .DATA_W   (DATA_W),
      .SET_BITS (SET_BITS),
      .LINE_W   (LINE_W)
   ) u_store (
      .clk   (clk),
      .rst   (rst),
      .clear (line_clear),
      .we    (line_we),
      .waddr (req_idx),
      .wline (wr_line),
      .raddr (req_idx),
      .rline (rd_line)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Writes allocate in LOOKUP regardless of hit; read misses fill on ack.
   always_comb begin
      state_nxt  = state;
      line_we    = 1'b0;
      line_clear = 1'b0;
      wr_line    = {1'b1, req_tag, req_wdata};
      case (state)
         IDLE: begin
            if (flush) begin
               line_clear = 1'b1;
            end else if (cpu_req) begin
               state_nxt = LOOKUP;
            end
         end
         LOOKUP: begin
            if (req_we) begin
               line_we   = 1'b1;
               state_nxt = MEM_WR;
            end else if (hit) begin
               state_nxt = RESP;
            end else begin
               state_nxt = MEM_RD;
            end
         end
         MEM_RD: begin
            if (mem_ack) begin
               line_we   = 1'b1;
               wr_line   = {1'b1, req_tag, mem_rdata};
               state_nxt = RESP;
            end
         end
         MEM_WR: begin
            if (mem_ack) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         cpu_rdata <= '0;
         cpu_hit   <= 1'b0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         if (accept) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
         end
         if (state == LOOKUP) begin
            cpu_hit <= hit;
            if (hit) begin
               if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
               if (!req_we) cpu_rdata <= rd_line[DATA_W-1:0];
            end else if (miss_cnt != CNT_MAX) begin
               miss_cnt <= miss_cnt + 1'b1;
            end
         end
         if ((state == MEM_RD) && mem_ack) begin
            cpu_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a small narrow-counter
// configuration so statistic saturation is reachable.
module tb_cache_ctrl;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 8;
   localparam int SET_BITS = 2;
   localparam int CNT_W    = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_ready;
   logic              cpu_valid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_hit;
   logic              flush = 1'b0;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   int errors = 0;
   int checks = 0;

   int          lat;
   int          memcyc;
   logic        done;
   logic [7:0]  got_rdata;
   logic        got_hit;
   logic [7:0]  m_addr;
   logic [7:0]  m_wdata;
   logic        m_we;
   logic        m_stable;
   int          valid_seen;
   int          memreq_seen;

   cache_ctrl #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .SET_BITS (SET_BITS),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_valid (cpu_valid),
      .cpu_rdata (cpu_rdata),
      .cpu_hit   (cpu_hit),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one request at a negedge, returns at the negedge after the accept edge.
   task automatic issueReq(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!cpu_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("ready_before_req", cpu_ready, 1);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   // Acts as the memory (ack on the wait_cycles-th MEM cycle) until cpu_valid.
   task automatic finishTxn(input int wait_cycles, input logic [7:0] data);
      lat      = 1;
      memcyc   = 0;
      done     = 1'b0;
      m_stable = 1'b1;
      m_addr   = '0;
      m_wdata  = '0;
      m_we     = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (mem_req) begin
            memcyc++;
            if (memcyc == 1) begin
               m_addr  = mem_addr;
               m_wdata = mem_wdata;
               m_we    = mem_we;
            end else if (m_addr !== mem_addr || m_wdata !== mem_wdata || m_we !== mem_we) begin
               m_stable = 1'b0;
            end
            mem_ack   = (memcyc == wait_cycles);
            mem_rdata = data;
         end else begin
            mem_ack = 1'b0;
         end
         if (cpu_valid) begin
            got_rdata = cpu_rdata;
            got_hit   = cpu_hit;
            done      = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      mem_ack = 1'b0;
      checkOutput("txn_completed", done, 1);
   endtask

   task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                input int wait_cycles, input logic [7:0] data);
      issueReq(we, addr, wdata);
      finishTxn(wait_cycles, data);
   endtask

   initial begin
      // Reset state
      #1;
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_cpu_valid", cpu_valid, 0);
      checkOutput("rst_cpu_hit", cpu_hit, 0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_hit_cnt", hit_cnt, 0);
      checkOutput("rst_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_cpu_ready", cpu_ready, 1);

      // 1: read miss with 3-cycle memory
      applyStimulus(1'b0, 8'h15, 8'h00, 3, 8'hA7);
      checkOutput("t1_latency", lat, 5);
      checkOutput("t1_memcyc", memcyc, 3);
      checkOutput("t1_mem_addr", m_addr, 8'h15);
      checkOutput("t1_mem_we", m_we, 0);
      checkOutput("t1_mem_stable", m_stable, 1);
      checkOutput("t1_rdata", got_rdata, 8'hA7);
      checkOutput("t1_hit", got_hit, 0);
      checkOutput("t1_miss_cnt", miss_cnt, 1);
      checkOutput("t1_hit_cnt", hit_cnt, 0);

      // 2: read hit
      applyStimulus(1'b0, 8'h15, 8'h00, 1, 8'hEE);
      checkOutput("t2_latency", lat, 2);
      checkOutput("t2_memcyc", memcyc, 0);
      checkOutput("t2_rdata", got_rdata, 8'hA7);
      checkOutput("t2_hit", got_hit, 1);
      checkOutput("t2_hit_cnt", hit_cnt, 1);

      // 3: conflicting tag on index 1, zero-wait memory
      applyStimulus(1'b0, 8'h25, 8'h00, 1, 8'h3C);
      checkOutput("t3_latency", lat, 3);
      checkOutput("t3_memcyc", memcyc, 1);
      checkOutput("t3_rdata", got_rdata, 8'h3C);
      checkOutput("t3_hit", got_hit, 0);
      checkOutput("t3_miss_cnt", miss_cnt, 2);
      applyStimulus(1'b0, 8'h15, 8'h00, 2, 8'hA7);
      checkOutput("t3_reread_hit", got_hit, 0);
      checkOutput("t3_reread_memcyc", memcyc, 2);
      checkOutput("t3_reread_rdata", got_rdata, 8'hA7);
      checkOutput("t3_miss_cnt2", miss_cnt, 3);

      // 4: write miss allocates, then read hit; miss counter already saturated
      applyStimulus(1'b1, 8'h08, 8'h42, 2, 8'h00);
      checkOutput("t4_latency", lat, 4);
      checkOutput("t4_mem_we", m_we, 1);
      checkOutput("t4_mem_addr", m_addr, 8'h08);
      checkOutput("t4_mem_wdata", m_wdata, 8'h42);
      checkOutput("t4_mem_stable", m_stable, 1);
      checkOutput("t4_hit", got_hit, 0);
      checkOutput("t4_miss_sat", miss_cnt, 3);
      applyStimulus(1'b0, 8'h08, 8'h00, 1, 8'hEE);
      checkOutput("t4_read_hit", got_hit, 1);
      checkOutput("t4_read_rdata", got_rdata, 8'h42);
      checkOutput("t4_read_memcyc", memcyc, 0);
      checkOutput("t4_hit_cnt", hit_cnt, 2);

      // 5: flush beats a simultaneous request
      @(negedge clk);
      flush    = 1'b1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 8'h08;
      #1;
      checkOutput("t5_ready_low", cpu_ready, 0);
      @(negedge clk);
      flush   = 1'b0;
      cpu_req = 1'b0;
      valid_seen  = 0;
      memreq_seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (cpu_valid) valid_seen++;
         if (mem_req) memreq_seen++;
         @(negedge clk);
      end
      checkOutput("t5_no_valid", valid_seen, 0);
      checkOutput("t5_no_memreq", memreq_seen, 0);
      applyStimulus(1'b0, 8'h08, 8'h00, 1, 8'h55);
      checkOutput("t5_read_hit", got_hit, 0);
      checkOutput("t5_read_rdata", got_rdata, 8'h55);
      checkOutput("t5_read_memcyc", memcyc, 1);
      applyStimulus(1'b1, 8'h08, 8'h99, 2, 8'h00);
      checkOutput("t5_write_hit", got_hit, 1);
      checkOutput("t5_write_wdata", m_wdata, 8'h99);
      checkOutput("t5_hit_cnt", hit_cnt, 3);
      applyStimulus(1'b0, 8'h08, 8'h00, 1, 8'hEE);
      checkOutput("t5_reread_rdata", got_rdata, 8'h99);
      checkOutput("t5_hit_sat", hit_cnt, 3);

      // 6: reset while waiting on memory
      issueReq(1'b0, 8'h15, 8'h00);
      @(negedge clk);
      checkOutput("t6_memreq_before", mem_req, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("t6_memreq_drop", mem_req, 0);
      checkOutput("t6_cpu_valid", cpu_valid, 0);
      checkOutput("t6_hit_cnt", hit_cnt, 0);
      checkOutput("t6_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      valid_seen = 0;
      for (int k = 0; k < 5; k++) begin
         if (cpu_valid) valid_seen++;
         @(negedge clk);
      end
      checkOutput("t6_no_valid", valid_seen, 0);
      applyStimulus(1'b0, 8'h15, 8'h00, 1, 8'hA7);
      checkOutput("t6_read_hit", got_hit, 0);
      checkOutput("t6_miss_cnt2", miss_cnt, 1);

      // 7: hit counter saturation
      for (int n = 0; n < 5; n++) begin
         applyStimulus(1'b0, 8'h15, 8'h00, 1, 8'hEE);
         checkOutput("t7_hit", got_hit, 1);
      end
      checkOutput("t7_hit_sat", hit_cnt, 3);
      checkOutput("t7_miss_cnt", miss_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
